// File: rtl/wb_regfile_sb.sv
// Writeback-side integer register file with bypassed read ports and a
// per-register pending-write scoreboard that produces the issue hazard stall.
module wb_regfile_sb #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int CNTW = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            wb_en,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   input  logic [4:0]      rs1_addr,
   input  logic [4:0]      rs2_addr,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   input  logic            rs1_used,
   input  logic            rs2_used,
   input  logic            iss_valid,
   input  logic            iss_we,
   input  logic [4:0]      iss_rd,
   input  logic            flush,
   output logic            stall,
   output logic            sb_err
);

   localparam logic [CNTW-1:0] CNT_MAX = '1;
   localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

   logic [XLEN-1:0] r_regs [NREG];
   logic [CNTW-1:0] r_cnt  [NREG];
   logic            r_sb_err;

   logic            w_dec1, w_dec2;
   logic [CNTW-1:0] w_eff1, w_eff2;
   logic            w_hz1, w_hz2, w_full;
   logic            w_accept, w_inc, w_dec, w_err_set;
   logic [NREG-1:0] w_inc_vec, w_dec_vec;

   // Write-first bypass lets a consumer see the retiring result in the same cycle.
   assign rs1_data = (rs1_addr == 5'd0) ? '0 :
                     (wb_en && wb_rd == rs1_addr) ? wb_data : r_regs[rs1_addr];
   assign rs2_data = (rs2_addr == 5'd0) ? '0 :
                     (wb_en && wb_rd == rs2_addr) ? wb_data : r_regs[rs2_addr];

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_dec1 = 1'b0;
      w_dec2 = 1'b0;
      w_eff1 = '0;
      w_eff2 = '0;
      w_hz1  = 1'b0;
      w_hz2  = 1'b0;
      w_full = 1'b0;
      if (rs1_addr != 5'd0) begin
         w_dec1 = wb_en && (wb_rd == rs1_addr) && (r_cnt[rs1_addr] != '0);
         w_eff1 = r_cnt[rs1_addr] - {{(CNTW-1){1'b0}}, w_dec1};
         w_hz1  = rs1_used && (w_eff1 != '0);
      end
      if (rs2_addr != 5'd0) begin
         w_dec2 = wb_en && (wb_rd == rs2_addr) && (r_cnt[rs2_addr] != '0);
         w_eff2 = r_cnt[rs2_addr] - {{(CNTW-1){1'b0}}, w_dec2};
         w_hz2  = rs2_used && (w_eff2 != '0);
      end
      // A retiring write to the same rd frees a slot, so a saturated counter may still accept.
      if (iss_we && iss_rd != 5'd0)
         w_full = (r_cnt[iss_rd] == CNT_MAX) && !(wb_en && wb_rd == iss_rd);
   end

   assign stall     = iss_valid && (w_hz1 || w_hz2 || w_full);
   assign w_accept  = iss_valid && !stall;
   assign w_inc     = w_accept && iss_we && (iss_rd != 5'd0);
   assign w_dec     = wb_en && (wb_rd != 5'd0) && (r_cnt[wb_rd] != '0);
   assign w_inc_vec = w_inc ? (NREG'(1) << iss_rd) : '0;
   assign w_dec_vec = w_dec ? (NREG'(1) << wb_rd) : '0;

   // Overflow is blocked by w_full; the first term only fires if that guard is broken.
   assign w_err_set = (w_inc && r_cnt[iss_rd] == CNT_MAX && !(w_dec && wb_rd == iss_rd))
                    || (w_accept && flush);

   // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sb_err <= 1'b0;
         // NOTE: the register array is reset because software may read any register before writing it.
         for (int i = 0; i < NREG; i++) begin
            r_regs[i] <= '0;
            r_cnt[i]  <= '0;
         end
      end else begin
         if (w_err_set)
            r_sb_err <= 1'b1;
         if (wb_en && wb_rd != 5'd0)
            r_regs[wb_rd] <= wb_data;
         for (int i = 0; i < NREG; i++) begin
            if (flush)
               r_cnt[i] <= '0;
            else begin
               case ({w_inc_vec[i], w_dec_vec[i]})
                  2'b10:   if (r_cnt[i] != CNT_MAX) r_cnt[i] <= r_cnt[i] + CNT_ONE;
                  2'b01:   r_cnt[i] <= r_cnt[i] - CNT_ONE;
                  default: r_cnt[i] <= r_cnt[i];
               endcase
            end
         end
      end
   end

   assign sb_err = r_sb_err;

endmodule
